// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with fixed response latency.
// Optional build macro DMEM_RANGE_CHECK_EN faults addresses beyond the RAM instead of wrapping them.
module dmem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [3:0]        req_be_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              ready_q;
  logic [31:0]       mem [DEPTH_WORDS];
  logic [IDX_W-1:0]  idx;
  logic              bad;
  logic              accept;

  assign idx    = req_addr_i[IDX_W+1:2];
  assign accept = req_valid_i & ready_q;

`ifdef DMEM_RANGE_CHECK_EN
  assign bad = (|req_addr_i[1:0]) | (|req_addr_i[ADDR_W-1:IDX_W+2]);
`else
  logic unused_hi;
  assign unused_hi = |req_addr_i[ADDR_W-1:IDX_W+2];
  assign bad       = |req_addr_i[1:0];
`endif

  assign req_ready_o  = ready_q;
  assign resp_valid_o = state_q == RESP;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

  // Next state: capture the response at accept, count down the latency, hold until handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (accept) begin
        err_d   = bad;
        rdata_d = (bad | req_we_i) ? 32'h0 : mem[idx];
        state_d = (LATENCY == 1) ? RESP : WAIT;
        cnt_d   = 4'(LATENCY - 1);
      end
      WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? RESP : WAIT;
      end
      RESP: if (resp_ready_i) begin
        state_d = IDLE;
        rdata_d = 32'h0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers; ready only asserts from the first edge after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ready_q <= state_d == IDLE;
    end
  end

  // Byte-enabled store committed at the accept edge; RAM contents survive reset.
  always_ff @(posedge clk_i) begin
    if (accept & req_we_i & ~bad)
      for (int i = 0; i < 4; i++)
        if (req_be_i[i]) mem[idx][8*i +: 8] <= req_wdata_i[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder (LATENCY=2, DEPTH_WORDS=256).
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  int          n_cmp = 0;
  int          n_err = 0;

  dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] er, input logic ee);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_wdata = 32'hx;
    req_be    = 4'hx;
    check({tag, "_wait"}, {30'h0, resp_valid, req_ready}, 32'h0);
    @(negedge clk);
    check({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
    check({tag, "_rdata"}, resp_rdata, er);
    check({tag, "_err"}, {31'h0, resp_err}, {31'h0, ee});
    @(negedge clk);
    check({tag, "_done"}, {30'h0, resp_valid, req_ready}, 32'h1);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_be     = 4'h0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h0);
    check("rst_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", {31'h0, resp_err}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'h0, req_ready}, 32'h1);

    xact("st_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    xact("ld_full", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    xact("st_b0", 1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 1'b0);
    xact("ld_b0", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
    xact("ld_mis", 1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1);
    xact("ld_after_mis", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
    xact("st_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
    xact("ld_after_be0", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
    xact("st_mis", 1'b1, 32'h11, 32'h0, 4'hF, 32'h0, 1'b1);
    xact("ld_after_stmis", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);

    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("stall_valid0", {31'h0, resp_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'h0, resp_valid}, 32'h1);
      check("stall_rdata", resp_rdata, 32'hDEADBEAA);
      check("stall_ready", {31'h0, req_ready}, 32'h0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", {31'h0, resp_valid}, 32'h0);
    check("stall_release_rdata", resp_rdata, 32'h0);
    check("stall_release_ready", {31'h0, req_ready}, 32'h1);

    xact("st_w0", 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
`ifdef DMEM_RANGE_CHECK_EN
    xact("ld_oor", 1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1);
`else
    xact("ld_alias", 1'b0, 32'h400, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
`endif

    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    req_be    = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("midrst_valid", {31'h0, resp_valid}, 32'h0);
    check("midrst_ready", {31'h0, req_ready}, 32'h0);
    repeat (3) @(negedge clk);
    check("midrst_hold_valid", {31'h0, resp_valid}, 32'h0);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("midrst_no_resp", {31'h0, resp_valid}, 32'h0);
    end
    xact("ld_after_rst", 1'b0, 32'h20, 32'h0, 4'h0, 32'h12345678, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
